// File: rtl/heat_pkg.sv
// Shared definitions for the heat-grid readout path: fixed-point format,
// RGB332 pixel layout and the step sequencer state encoding.
package heat_pkg;

    localparam int unsigned FP_W         = 32;
    localparam int unsigned FP_FRAC_BITS = 27;
    // One colour level per 1/8 of a unit.
    localparam int unsigned COLOR_SHIFT  = FP_FRAC_BITS - 3;

    localparam int unsigned RGB_R_W = 3;
    localparam int unsigned RGB_G_W = 3;
    localparam int unsigned RGB_B_W = 2;

    // Field order fixes the RGB332 bit positions: r=[7:5], g=[4:2], b=[1:0].
    typedef struct packed {
        logic [RGB_R_W-1:0] r;
        logic [RGB_G_W-1:0] g;
        logic [RGB_B_W-1:0] b;
    } rgb332_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DROP = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DUMP      = 3'd4,
        ST_ADVANCE   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/heat_color_map.sv
// Combinational signed fixed-point to RGB332 mapping: positive values shade
// red, negative values shade blue, zero is black.
module heat_color_map
    import heat_pkg::*;
(
    input  logic [FP_W-1:0] value,
    output rgb332_t         color_c
);

    logic [FP_W-1:0] mag;
    logic [FP_W-1:0] level_full;
    logic [2:0]      level;

    // Two's-complement magnitude; the most negative value maps to 2^31, which
    // lands on the saturated level anyway.
    always_comb begin
        mag        = value[FP_W-1] ? FP_W'(~value + 1'b1) : value;
        level_full = mag >> COLOR_SHIFT;
        level      = (level_full > FP_W'(7)) ? 3'd7 : level_full[2:0];

        color_c = '0;
        if (value != '0) begin
            if (!value[FP_W-1]) begin
                color_c.r = level;
            end else begin
                color_c.b = level[2:1];
            end
        end
    end

endmodule

// File: rtl/grid_step_sequencer.sv
// Lock-step controller for the heat-grid column array: pulses start, waits for
// every column flag, then streams one RGB332 pixel per column to the writer.
module grid_step_sequencer
    import heat_pkg::*;
#(
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned ROW_BITS = 7,
    parameter int unsigned COL_BITS = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       cols_init_done,
    input  logic                       frame_en,
    input  logic [ROW_BITS:0]          height,
    input  logic [NUM_COLS-1:0]        col_flag,
    input  logic [FP_W*NUM_COLS-1:0]   col_node,
    output logic                       start,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [COL_BITS:0]          pix_x,
    output logic [ROW_BITS:0]          pix_y,
    output logic [7:0]                 pix_color,
    output logic [ROW_BITS:0]          row_idx,
    output logic [15:0]                sweep_count,
    output logic                       busy
);

    localparam int unsigned XW    = COL_BITS + 1;
    localparam int unsigned YW    = ROW_BITS + 1;
    localparam int unsigned IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

    seq_state_e       state_q, state_d;
    logic             dump_en_q, dump_en_d;
    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic             start_q, start_d;
    logic             pix_valid_q, pix_valid_d;
    logic [XW-1:0]    pix_x_q, pix_x_d;
    logic [YW-1:0]    pix_y_q, pix_y_d;
    logic [7:0]       pix_color_q, pix_color_d;
    logic [YW-1:0]    row_q, row_d;
    logic [15:0]      sweep_q, sweep_d;
    logic             busy_q, busy_d;
    logic             capture_en;

    logic [FP_W-1:0]  cap_q [NUM_COLS];
    logic [FP_W-1:0]  map_in;
    rgb332_t          map_out;

    heat_color_map u_color_map (
        .value   (map_in),
        .color_c (map_out)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        dump_en_d   = dump_en_q;
        idx_d       = idx_q;
        start_d     = 1'b0;
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;
        row_d       = row_q;
        sweep_d     = sweep_q;
        capture_en  = 1'b0;
        nxt_idx     = (idx_q == LAST_IDX) ? '0 : IDX_W'(idx_q + 1'b1);
        map_in      = cap_q[nxt_idx];

        case (state_q)
            ST_IDLE: begin
                if (run && cols_init_done) begin
                    state_d   = ST_ISSUE;
                    dump_en_d = frame_en;
                    start_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (col_flag == '0) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // The first pixel is mapped straight from the bus as it is captured.
                map_in = col_node[FP_W-1:0];
                if (&col_flag) begin
                    capture_en = 1'b1;
                    idx_d      = '0;
                    if (dump_en_q) begin
                        state_d     = ST_DUMP;
                        pix_valid_d = 1'b1;
                        pix_x_d     = '0;
                        pix_y_d     = row_q;
                        pix_color_d = map_out;
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end
            end
            ST_DUMP: begin
                if (pix_ready) begin
                    if (idx_q == LAST_IDX) begin
                        pix_valid_d = 1'b0;
                        state_d     = ST_ADVANCE;
                    end else begin
                        idx_d       = nxt_idx;
                        pix_x_d     = XW'(nxt_idx);
                        pix_color_d = map_out;
                    end
                end
            end
            ST_ADVANCE: begin
                if (row_q >= height) begin
                    row_d   = '0;
                    sweep_d = sweep_q + 16'd1;
                end else begin
                    row_d = YW'(row_q + 1'b1);
                end
                if (run) begin
                    state_d   = ST_ISSUE;
                    dump_en_d = frame_en;
                    start_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dump_en_q   <= 1'b0;
            idx_q       <= '0;
            start_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            row_q       <= '0;
            sweep_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dump_en_q   <= dump_en_d;
            idx_q       <= idx_d;
            start_q     <= start_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            row_q       <= row_d;
            sweep_q     <= sweep_d;
            busy_q      <= busy_d;
        end
    end

    // Node snapshot taken when every column reports done.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                cap_q[i] <= col_node[FP_W*i +: FP_W];
            end
        end
    end

    assign start       = start_q;
    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_color   = pix_color_q;
    assign row_idx     = row_q;
    assign sweep_count = sweep_q;
    assign busy        = busy_q;

endmodule
